// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the RAM.
// slave is the arbiter side, master is the requester/RAM side.
interface mem_arbiter_if;
  logic        m0_req_valid_i;
  logic [31:0] m0_req_addr_i;
  logic        m0_req_ready_o;
  logic        m0_rsp_valid_o;
  logic [31:0] m0_rsp_data_o;

  logic        m1_req_valid_i;
  logic [31:0] m1_req_addr_i;
  logic        m1_req_ready_o;
  logic        m1_rsp_valid_o;
  logic [31:0] m1_rsp_data_o;

  logic        m1_wr_valid_i;
  logic [31:0] m1_wr_addr_i;
  logic [31:0] m1_wr_data_i;
  logic [3:0]  m1_wr_mask_i;
  logic        m1_wr_ready_o;
  logic        m1_wr_rsp_valid_o;

  logic        ram_rd_valid_o;
  logic [31:0] ram_rd_addr_o;
  logic        ram_rd_res_valid_i;
  logic [31:0] ram_rd_data_i;

  logic        ram_wr_valid_o;
  logic [31:0] ram_wr_addr_o;
  logic [31:0] ram_wr_data_o;
  logic [3:0]  ram_wr_mask_o;
  logic        ram_wr_res_valid_i;

  modport slave (
    input  m0_req_valid_i, m0_req_addr_i,
    output m0_req_ready_o, m0_rsp_valid_o, m0_rsp_data_o,
    input  m1_req_valid_i, m1_req_addr_i,
    output m1_req_ready_o, m1_rsp_valid_o, m1_rsp_data_o,
    input  m1_wr_valid_i, m1_wr_addr_i, m1_wr_data_i, m1_wr_mask_i,
    output m1_wr_ready_o, m1_wr_rsp_valid_o,
    output ram_rd_valid_o, ram_rd_addr_o,
    input  ram_rd_res_valid_i, ram_rd_data_i,
    output ram_wr_valid_o, ram_wr_addr_o, ram_wr_data_o, ram_wr_mask_o,
    input  ram_wr_res_valid_i
  );

  modport master (
    output m0_req_valid_i, m0_req_addr_i,
    input  m0_req_ready_o, m0_rsp_valid_o, m0_rsp_data_o,
    output m1_req_valid_i, m1_req_addr_i,
    input  m1_req_ready_o, m1_rsp_valid_o, m1_rsp_data_o,
    output m1_wr_valid_i, m1_wr_addr_i, m1_wr_data_i, m1_wr_mask_i,
    input  m1_wr_ready_o, m1_wr_rsp_valid_o,
    input  ram_rd_valid_o, ram_rd_addr_o,
    output ram_rd_res_valid_i, ram_rd_data_i,
    input  ram_wr_valid_o, ram_wr_addr_o, ram_wr_data_o, ram_wr_mask_o,
    output ram_wr_res_valid_i
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port read arbiter (ifetch m0, data m1) plus pass-through data write
// port onto a single RAM with one-cycle read latency.
module mem_arbiter #(
  parameter logic [31:0] MEM_BYTES = 32'h0001_0000
) (
  input logic          clk_i,
  input logic          rst_ni,
  mem_arbiter_if.slave bus
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        last_q;
  logic        owner_q;
  logic        oor_rd_q;
  logic        oor_wr_q;
  logic        fresh_q;
  logic [31:0] addr_q;

  logic        pick;
  logic [31:0] pick_addr;
  logic        hazard;
  logic        grant;
  logic        rd_in;
  logic        wr_acc;
  logic        wr_in;
  logic        rsp_live;
  logic        rd_hit;
  logic [31:0] rd_data;

  always_comb begin
    if (bus.m0_req_valid_i && bus.m1_req_valid_i) begin
      pick = ~last_q;
    end else begin
      pick = bus.m1_req_valid_i;
    end
    pick_addr = pick ? bus.m1_req_addr_i : bus.m0_req_addr_i;
    // a read to the word being written this cycle waits one cycle
    hazard = bus.m1_wr_valid_i &&
             (pick_addr[31:2] == bus.m1_wr_addr_i[31:2]);
    grant  = rst_ni && (state == IDLE) && !hazard &&
             (bus.m0_req_valid_i || bus.m1_req_valid_i);
    rd_in  = pick_addr < MEM_BYTES;
    wr_acc = rst_ni && bus.m1_wr_valid_i;
    wr_in  = bus.m1_wr_addr_i < MEM_BYTES;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: state_nxt = grant ? RESP : IDLE;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      oor_rd_q <= 1'b0;
      oor_wr_q <= 1'b0;
      fresh_q  <= 1'b1;
      addr_q   <= '0;
    end else begin
      fresh_q  <= 1'b0;
      oor_wr_q <= wr_acc && !wr_in;
      if (grant) begin
        last_q   <= pick;
        owner_q  <= pick;
        oor_rd_q <= !rd_in;
        addr_q   <= pick_addr;
      end
    end
  end

  always_comb begin
    rsp_live = rst_ni && !fresh_q && (state == RESP);
    rd_hit   = oor_rd_q ? 1'b1 : bus.ram_rd_res_valid_i;
    rd_data  = oor_rd_q ? 32'h0 : bus.ram_rd_data_i;

    bus.m0_req_ready_o = grant && !pick;
    bus.m1_req_ready_o = grant && pick;
    bus.m0_rsp_valid_o = rsp_live && !owner_q && rd_hit;
    bus.m1_rsp_valid_o = rsp_live && owner_q && rd_hit;
    bus.m0_rsp_data_o  = !owner_q ? rd_data : 32'h0;
    bus.m1_rsp_data_o  = owner_q ? rd_data : 32'h0;

    // RAM aligns read bytes using the address seen in the response cycle
    bus.ram_rd_valid_o = grant && rd_in;
    if (state == RESP) begin
      bus.ram_rd_addr_o = addr_q;
    end else begin
      bus.ram_rd_addr_o = grant ? pick_addr : 32'h0;
    end

    bus.m1_wr_ready_o     = rst_ni;
    bus.ram_wr_valid_o    = wr_acc && wr_in;
    bus.ram_wr_addr_o     = bus.m1_wr_addr_i;
    bus.ram_wr_data_o     = bus.m1_wr_data_i;
    bus.ram_wr_mask_o     = bus.m1_wr_mask_i;
    bus.m1_wr_rsp_valid_o = rst_ni && !fresh_q &&
                            (bus.ram_wr_res_valid_i || oor_wr_q);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a RAM model
// and a transaction-level reference model.
module tb_mem_arbiter;

  localparam logic [31:0] MB = 32'h0001_0000;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mem_arbiter_if bus ();

  mem_arbiter #(.MEM_BYTES(MB)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ram [bit [29:0]];
  logic [31:0] mdl [bit [29:0]];
  logic        rd_res_q = 1'b0;
  logic        wr_res_q = 1'b0;
  logic [31:0] rd_data_q = 32'h0;
  logic        late_rd = 1'b0;
  logic        late_wr = 1'b0;

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0]  m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (a >= MB) return 32'h0;
    if (mdl.exists(a[31:2])) return mdl[a[31:2]];
    return 32'h0;
  endfunction

  // RAM: one-cycle read and write response
  always @(posedge clk) begin
    logic [31:0] old;
    rd_res_q <= bus.ram_rd_valid_o;
    wr_res_q <= bus.ram_wr_valid_o;
    if (bus.ram_rd_valid_o) begin
      rd_data_q <= ram.exists(bus.ram_rd_addr_o[31:2]) ?
                   ram[bus.ram_rd_addr_o[31:2]] : 32'h0;
    end
    if (bus.ram_wr_valid_o) begin
      old = ram.exists(bus.ram_wr_addr_o[31:2]) ?
            ram[bus.ram_wr_addr_o[31:2]] : 32'h0;
      ram[bus.ram_wr_addr_o[31:2]] =
        merge(old, bus.ram_wr_data_o, bus.ram_wr_mask_o);
    end
  end

  assign bus.ram_rd_res_valid_i = rd_res_q | late_rd;
  assign bus.ram_rd_data_i      = rd_data_q;
  assign bus.ram_wr_res_valid_i = wr_res_q | late_wr;

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    ram[a[31:2]] = d;
    mdl[a[31:2]] = d;
  endtask

  task automatic idle_in();
    bus.m0_req_valid_i = 1'b0;
    bus.m0_req_addr_i  = 32'h0;
    bus.m1_req_valid_i = 1'b0;
    bus.m1_req_addr_i  = 32'h0;
    bus.m1_wr_valid_i  = 1'b0;
    bus.m1_wr_addr_i   = 32'h0;
    bus.m1_wr_data_i   = 32'h0;
    bus.m1_wr_mask_i   = 4'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.m0_req_valid_i = 1'b1;
    bus.m0_req_addr_i  = 32'h10;
    bus.m1_req_valid_i = 1'b1;
    bus.m1_req_addr_i  = 32'h20;
    bus.m1_wr_valid_i  = 1'b1;
    bus.m1_wr_addr_i   = 32'h30;
    bus.m1_wr_mask_i   = 4'hf;
    step();
    @(negedge clk);
    total++;
    if ({bus.m0_req_ready_o, bus.m1_req_ready_o, bus.m1_wr_ready_o}
        !== 3'b000) begin
      bad++;
      $display("FAIL reset_ready got=%b exp=000",
        {bus.m0_req_ready_o, bus.m1_req_ready_o, bus.m1_wr_ready_o});
    end
    total++;
    if ({bus.m0_rsp_valid_o, bus.m1_rsp_valid_o, bus.m1_wr_rsp_valid_o,
         bus.ram_rd_valid_o, bus.ram_wr_valid_o} !== 5'b0) begin
      bad++;
      $display("FAIL reset_valid got=%b exp=00000",
        {bus.m0_rsp_valid_o, bus.m1_rsp_valid_o, bus.m1_wr_rsp_valid_o,
         bus.ram_rd_valid_o, bus.ram_wr_valid_o});
    end
    idle_in();
    step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    total++;
    if (bus.m1_wr_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL wr_ready_after_reset got=%b exp=1", bus.m1_wr_ready_o);
    end
    step();
  endtask

  task automatic test_single_read();
    preload(32'h100, 32'hCAFE_0100);
    bus.m0_req_valid_i = 1'b1;
    bus.m0_req_addr_i  = 32'h100;
    @(negedge clk);
    total++;
    if ({bus.m0_req_ready_o, bus.ram_rd_valid_o} !== 2'b11 ||
        bus.ram_rd_addr_o !== 32'h100) begin
      bad++;
      $display("FAIL single_req got rdy=%b rv=%b a=%h exp 1 1 100",
        bus.m0_req_ready_o, bus.ram_rd_valid_o, bus.ram_rd_addr_o);
    end
    step();
    idle_in();
    @(negedge clk);
    total++;
    if (bus.m0_rsp_valid_o !== 1'b1 || bus.m0_rsp_data_o !== 32'hCAFE_0100
        || bus.m1_rsp_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL single_rsp got v=%b d=%h v1=%b exp 1 cafe0100 0",
        bus.m0_rsp_valid_o, bus.m0_rsp_data_o, bus.m1_rsp_valid_o);
    end
    total++;
    if (bus.ram_rd_valid_o !== 1'b0 || bus.ram_rd_addr_o !== 32'h100) begin
      bad++;
      $display("FAIL single_resp_addr got v=%b a=%h exp 0 100",
        bus.ram_rd_valid_o, bus.ram_rd_addr_o);
    end
    step();
    @(negedge clk);
    total++;
    if (bus.ram_rd_addr_o !== 32'h0 || bus.m0_rsp_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL idle_addr got a=%h v=%b exp 0 0",
        bus.ram_rd_addr_o, bus.m0_rsp_valid_o);
    end
    step();
  endtask

  task automatic test_round_robin();
    logic [31:0] ad [2];
    int          p;
    ad[0] = 32'h40;
    ad[1] = 32'h80;
    preload(ad[0], 32'h0000_AA40);
    preload(ad[1], 32'h0000_BB80);
    idle_in();
    rst_n = 1'b0;
    bus.m0_req_valid_i = 1'b1;
    bus.m0_req_addr_i  = ad[0];
    bus.m1_req_valid_i = 1'b1;
    bus.m1_req_addr_i  = ad[1];
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      p = (i / 2) % 2;
      @(negedge clk);
      total++;
      if (i % 2 == 0) begin
        if ({bus.m1_req_ready_o, bus.m0_req_ready_o} !== (2'b01 << p) ||
            {bus.m1_rsp_valid_o, bus.m0_rsp_valid_o} !== 2'b00) begin
          bad++;
          $display("FAIL rr_grant c=%0d got rdy=%b rsp=%b exp rdy=%b",
            i, {bus.m1_req_ready_o, bus.m0_req_ready_o},
            {bus.m1_rsp_valid_o, bus.m0_rsp_valid_o}, 2'b01 << p);
        end
      end else begin
        if ({bus.m1_req_ready_o, bus.m0_req_ready_o} !== 2'b00 ||
            {bus.m1_rsp_valid_o, bus.m0_rsp_valid_o} !== (2'b01 << p) ||
            (p == 0 ? bus.m0_rsp_data_o : bus.m1_rsp_data_o)
              !== rd_model(ad[p])) begin
          bad++;
          $display("FAIL rr_resp c=%0d got rdy=%b rsp=%b exp rsp=%b",
            i, {bus.m1_req_ready_o, bus.m0_req_ready_o},
            {bus.m1_rsp_valid_o, bus.m0_rsp_valid_o}, 2'b01 << p);
        end
      end
      step();
    end
    idle_in();
    step();
  endtask

  task automatic test_hazard();
    preload(32'h200, 32'h1111_1111);
    bus.m1_wr_valid_i  = 1'b1;
    bus.m1_wr_addr_i   = 32'h200;
    bus.m1_wr_data_i   = 32'hAABB_CCDD;
    bus.m1_wr_mask_i   = 4'b0011;
    bus.m1_req_valid_i = 1'b1;
    bus.m1_req_addr_i  = 32'h202;
    @(negedge clk);
    total++;
    if ({bus.m0_req_ready_o, bus.m1_req_ready_o} !== 2'b00 ||
        {bus.m1_wr_ready_o, bus.ram_wr_valid_o} !== 2'b11) begin
      bad++;
      $display("FAIL hazard_hold got rdy=%b wr=%b exp 00 11",
        {bus.m0_req_ready_o, bus.m1_req_ready_o},
        {bus.m1_wr_ready_o, bus.ram_wr_valid_o});
    end
    mdl[30'h80] = merge(mdl[30'h80], 32'hAABB_CCDD, 4'b0011);
    step();
    bus.m1_wr_valid_i = 1'b0;
    @(negedge clk);
    total++;
    if (bus.m1_req_ready_o !== 1'b1 || bus.m1_wr_rsp_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL hazard_grant got rdy=%b wrsp=%b exp 1 1",
        bus.m1_req_ready_o, bus.m1_wr_rsp_valid_o);
    end
    step();
    idle_in();
    @(negedge clk);
    total++;
    if (bus.m1_rsp_valid_o !== 1'b1 || bus.m1_rsp_data_o !== 32'h1111_CCDD)
    begin
      bad++;
      $display("FAIL hazard_data got v=%b d=%h exp 1 1111ccdd",
        bus.m1_rsp_valid_o, bus.m1_rsp_data_o);
    end
    step();
  endtask

  task automatic test_out_of_range();
    bus.m0_req_valid_i = 1'b1;
    bus.m0_req_addr_i  = MB;
    @(negedge clk);
    total++;
    if (bus.m0_req_ready_o !== 1'b1 || bus.ram_rd_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL oor_rd_req got rdy=%b rv=%b exp 1 0",
        bus.m0_req_ready_o, bus.ram_rd_valid_o);
    end
    step();
    idle_in();
    @(negedge clk);
    total++;
    if (bus.m0_rsp_valid_o !== 1'b1 || bus.m0_rsp_data_o !== 32'h0) begin
      bad++;
      $display("FAIL oor_rd_rsp got v=%b d=%h exp 1 0",
        bus.m0_rsp_valid_o, bus.m0_rsp_data_o);
    end
    step();
    bus.m1_wr_valid_i = 1'b1;
    bus.m1_wr_addr_i  = 32'hFFFF_FFF0;
    bus.m1_wr_data_i  = 32'h1234_5678;
    bus.m1_wr_mask_i  = 4'hf;
    @(negedge clk);
    total++;
    if (bus.m1_wr_ready_o !== 1'b1 || bus.ram_wr_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL oor_wr_req got rdy=%b wv=%b exp 1 0",
        bus.m1_wr_ready_o, bus.ram_wr_valid_o);
    end
    step();
    idle_in();
    @(negedge clk);
    total++;
    if (bus.m1_wr_rsp_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL oor_wr_rsp got=%b exp=1", bus.m1_wr_rsp_valid_o);
    end
    step();
    @(negedge clk);
    total++;
    if (bus.m1_wr_rsp_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL oor_wr_single got=%b exp=0", bus.m1_wr_rsp_valid_o);
    end
    step();
  endtask

  task automatic test_reset_in_resp();
    bus.m0_req_valid_i = 1'b1;
    bus.m0_req_addr_i  = 32'h40;
    @(negedge clk);
    total++;
    if (bus.m0_req_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL rir_accept got=%b exp=1", bus.m0_req_ready_o);
    end
    step();
    idle_in();
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.m0_rsp_valid_o, bus.m1_rsp_valid_o} !== 2'b00) begin
      bad++;
      $display("FAIL rir_in_reset got=%b exp=00",
        {bus.m0_rsp_valid_o, bus.m1_rsp_valid_o});
    end
    step();
    rst_n   = 1'b1;
    late_rd = 1'b1;
    late_wr = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.m0_rsp_valid_o, bus.m1_rsp_valid_o, bus.m1_wr_rsp_valid_o}
        !== 3'b000) begin
      bad++;
      $display("FAIL rir_late got=%b exp=000",
        {bus.m0_rsp_valid_o, bus.m1_rsp_valid_o, bus.m1_wr_rsp_valid_o});
    end
    step();
    late_rd = 1'b0;
    late_wr = 1'b0;
    bus.m0_req_valid_i = 1'b1;
    bus.m0_req_addr_i  = 32'h40;
    bus.m1_req_valid_i = 1'b1;
    bus.m1_req_addr_i  = 32'h80;
    @(negedge clk);
    total++;
    if ({bus.m1_req_ready_o, bus.m0_req_ready_o} !== 2'b01) begin
      bad++;
      $display("FAIL rir_first_grant got=%b exp=01",
        {bus.m1_req_ready_o, bus.m0_req_ready_o});
    end
    step();
    idle_in();
    step();
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return MB + (32'($urandom_range(0, 3)) << 2);
    return 32'h300 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
  endfunction

  task automatic test_random();
    logic        rq_v [2];
    logic [31:0] rq_a [2];
    logic        wr_v;
    logic        busy;
    logic        last;
    logic        pend_v;
    logic        pend_p;
    logic [31:0] pend_d;
    logic        wr_pend;
    logic [1:0]  exp_r;
    logic        p;
    do_reset();
    rq_v[0] = 1'b0;
    rq_v[1] = 1'b0;
    rq_a[0] = 32'h0;
    rq_a[1] = 32'h0;
    busy    = 1'b0;
    last    = 1'b1;
    pend_v  = 1'b0;
    pend_p  = 1'b0;
    pend_d  = 32'h0;
    wr_pend = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!rq_v[k] && $urandom_range(0, 2) != 0) begin
          rq_v[k] = 1'b1;
          rq_a[k] = rand_addr();
        end
      end
      wr_v = ($urandom_range(0, 2) == 0);
      bus.m0_req_valid_i = rq_v[0];
      bus.m0_req_addr_i  = rq_a[0];
      bus.m1_req_valid_i = rq_v[1];
      bus.m1_req_addr_i  = rq_a[1];
      bus.m1_wr_valid_i  = wr_v;
      bus.m1_wr_addr_i   = rand_addr();
      bus.m1_wr_data_i   = $urandom;
      bus.m1_wr_mask_i   = 4'($urandom_range(0, 15));
      @(negedge clk);
      exp_r = 2'b00;
      if (!busy && (rq_v[0] || rq_v[1])) begin
        p = (rq_v[0] && rq_v[1]) ? ~last : rq_v[1];
        if (!(wr_v && rq_a[p][31:2] == bus.m1_wr_addr_i[31:2]))
          exp_r[p] = 1'b1;
      end
      total++;
      if ({bus.m1_req_ready_o, bus.m0_req_ready_o} !== exp_r) begin
        bad++;
        $display("FAIL rnd_ready c=%0d got=%b exp=%b", c,
          {bus.m1_req_ready_o, bus.m0_req_ready_o}, exp_r);
      end
      total++;
      if ({bus.m1_rsp_valid_o, bus.m0_rsp_valid_o} !==
          (pend_v ? (2'b01 << pend_p) : 2'b00)) begin
        bad++;
        $display("FAIL rnd_rsp_valid c=%0d got=%b exp_v=%b port=%b", c,
          {bus.m1_rsp_valid_o, bus.m0_rsp_valid_o}, pend_v, pend_p);
      end
      if (pend_v) begin
        total++;
        if ((pend_p ? bus.m1_rsp_data_o : bus.m0_rsp_data_o) !== pend_d) begin
          bad++;
          $display("FAIL rnd_rsp_data c=%0d got=%h exp=%h", c,
            pend_p ? bus.m1_rsp_data_o : bus.m0_rsp_data_o, pend_d);
        end
      end
      total++;
      if (bus.m1_wr_rsp_valid_o !== wr_pend ||
          bus.ram_wr_valid_o !== (wr_v && bus.m1_wr_addr_i < MB)) begin
        bad++;
        $display("FAIL rnd_write c=%0d got rsp=%b wv=%b exp rsp=%b", c,
          bus.m1_wr_rsp_valid_o, bus.ram_wr_valid_o, wr_pend);
      end
      pend_v = 1'b0;
      busy   = 1'b0;
      if (exp_r != 2'b00) begin
        p      = exp_r[1];
        pend_v = 1'b1;
        pend_p = p;
        pend_d = rd_model(rq_a[p]);
        last   = p;
        busy   = 1'b1;
        rq_v[p] = 1'b0;
      end
      wr_pend = wr_v;
      if (wr_v && bus.m1_wr_addr_i < MB) begin
        mdl[bus.m1_wr_addr_i[31:2]] =
          merge(rd_model({bus.m1_wr_addr_i[31:2], 2'b00}),
                bus.m1_wr_data_i, bus.m1_wr_mask_i);
      end
      step();
    end
    idle_in();
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle_in();
    test_reset();
    test_single_read();
    test_round_robin();
    test_hazard();
    test_out_of_range();
    test_reset_in_resp();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
